// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
// The fetch_entry_t type pairs a returned instruction word with the PC it was fetched from.
package fetch_pkg;

    localparam int INSTR_W = 32;
    localparam int XLEN    = 64;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h00000013;

    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of fetch_entry_t. Latency: a push is visible at the head next cycle; no bypass.
// Backpressure: pop is ignored when empty, push is ignored when full unless a pop frees the slot; clear wins.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   push,
    input  fetch_entry_t           push_dat,
    input  logic                   pop,
    output logic                   head_vld,
    output fetch_entry_t           head_dat,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        do_pop   = pop && (count_q != '0) && !clear;
        do_push  = push && !clear && ((count_q != CNT_W'(DEPTH)) || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; validity is tracked purely by count_q.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_dat;
        end
    end

    assign head_vld = (count_q != '0);
    assign head_dat = mem_q[rd_ptr_q];
    assign count    = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Fetch front end: owns fetch PC, issues credit-limited imem requests, buffers words for IF/ID (FETCH_PERF_CNT_EN adds perf counters).
// Latency: 2 cycles minimum request-to-output; out_ready=0 holds the head and fetching stops once credits run out.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int          DEPTH           = 4,
    parameter int          MAX_OUTSTANDING = 2,
    parameter logic [63:0] RESET_PC        = 64'h0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               redirect,
    input  logic [XLEN-1:0]    redirect_pc,
    input  logic               out_ready,
    output logic               imem_req,
    output logic [XLEN-1:0]    imem_addr,
    input  logic               imem_gnt,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr_out,
    output logic [XLEN-1:0]    pc_out
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]        perf_empty_cycles,
    output logic [31:0]        perf_dropped
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int CRD_W = CNT_W + 1;

    logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0]  resp_pc_q, resp_pc_d;
    logic [CNT_W-1:0] outst_q, outst_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic [CNT_W-1:0] fifo_count;
    logic [CRD_W-1:0] credit_used;
    logic             accept;
    logic             push;
    logic             pop;
    logic             head_vld;
    fetch_entry_t     head_dat;
    fetch_entry_t     push_entry;

    always_comb begin
        // Slots already promised: buffered words plus live (non-dropped) requests in flight.
        credit_used = {1'b0, fifo_count} + {1'b0, outst_q} - {1'b0, drop_q};
        imem_req    = reset && !redirect
                      && (outst_q < CNT_W'(MAX_OUTSTANDING))
                      && (credit_used < CRD_W'(DEPTH));
        accept      = imem_req && imem_gnt;
        push        = imem_rvalid && !redirect && (drop_q == '0);
        pop         = head_vld && out_ready && !redirect;

        push_entry.pc    = resp_pc_q;
        push_entry.instr = imem_rdata;

        outst_d    = outst_q + CNT_W'(accept) - CNT_W'(imem_rvalid);
        drop_d     = drop_q;
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;

        if (redirect) begin
            drop_d     = outst_q - CNT_W'(imem_rvalid);
            fetch_pc_d = word_align(redirect_pc);
            resp_pc_d  = word_align(redirect_pc);
        end else begin
            if (imem_rvalid && (drop_q != '0)) begin
                drop_d = drop_q - CNT_W'(1);
            end
            if (accept) begin
                fetch_pc_d = fetch_pc_q + 64'd4;
            end
            if (push) begin
                resp_pc_d = resp_pc_q + 64'd4;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            outst_q    <= '0;
            drop_q     <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
        end
    end

    fetch_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .clear    (redirect),
        .push     (push),
        .push_dat (push_entry),
        .pop      (pop),
        .head_vld (head_vld),
        .head_dat (head_dat),
        .count    (fifo_count)
    );

    assign imem_addr   = fetch_pc_q;
    assign instr_valid = head_vld;
    assign instr_out   = head_vld ? head_dat.instr : NOP_INSTR;
    assign pc_out      = head_vld ? head_dat.pc : '0;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_empty_q;
    logic [31:0] perf_drop_q;
    logic        rsp_drop;

    assign rsp_drop = imem_rvalid && (redirect || (drop_q != '0));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_empty_q <= '0;
            perf_drop_q  <= '0;
        end else begin
            if (out_ready && !head_vld && !redirect && (perf_empty_q != '1)) begin
                perf_empty_q <= perf_empty_q + 32'd1;
            end
            if (rsp_drop && (perf_drop_q != '1)) begin
                perf_drop_q <= perf_drop_q + 32'd1;
            end
        end
    end

    assign perf_empty_cycles = perf_empty_q;
    assign perf_dropped      = perf_drop_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: in-order memory model with variable latency, scoreboard of
// expected {pc, instr} pushed at request acceptance and popped by an independent output monitor.
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam int          DEPTH    = 4;
    localparam int          MAXO     = 2;
    localparam logic [63:0] RESET_PC = 64'h0;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect;
    logic [63:0] redirect_pc;
    logic        out_ready;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr_out;
    logic [63:0] pc_out;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_empty_cycles;
    logic [31:0] perf_dropped;
`endif

    always #5 clk = ~clk;

    fetch_unit #(
        .DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO), .RESET_PC(RESET_PC)
    ) dut (
        .clk(clk), .reset(reset), .redirect(redirect), .redirect_pc(redirect_pc),
        .out_ready(out_ready), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr_out(instr_out), .pc_out(pc_out)
`ifdef FETCH_PERF_CNT_EN
        , .perf_empty_cycles(perf_empty_cycles), .perf_dropped(perf_dropped)
`endif
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    // Knobs per phase (percentages and latency range).
    int p_gnt = 100, p_ready = 100, p_redirect = 0, lat_min = 1, lat_max = 1;
    bit force_tgt = 0;
    logic [63:0] forced_pc = 64'h100;

    // Memory model: accepted requests in order with their due cycle and flush epoch.
    logic [63:0] pend_addr[$];
    int          pend_rdy[$];
    int          pend_epoch[$];
    int          last_rdy = 0;
    int          epoch = 0;
    int          tb_out = 0;
    logic [63:0] next_addr = RESET_PC;

    // Scoreboard: PCs expected at the output, in order.
    logic [63:0] sb_q[$];
    logic [63:0] exp_pc;
    bit          redir_prev = 0;

    bit track_lat = 0;
    int first_acc = -1, first_val = -1;
    int tb_dropped = 0, tb_empty = 0;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return (a[31:0] * 32'h9E3779B1) ^ a[63:32] ^ 32'h5A5A0013;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [63:0] pick_target();
        logic [63:0] t;
        if (force_tgt) return forced_pc;
        case ($urandom_range(0, 3))
            0:       t = {32'h0, $urandom} & 64'h0000_0000_0000_FFFF;
            1:       t = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
            default: t = 64'h100 + 64'($urandom_range(0, 255));
        endcase
        return t;
    endfunction

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            int          out_before;
            int          rdy;
            bit          exp_req;
            logic [63:0] tgt;
            @(negedge clk);
            cyc++;
            tgt         = pick_target();
            redirect    = ($urandom_range(0, 99) < p_redirect);
            redirect_pc = tgt;
            imem_gnt    = ($urandom_range(0, 99) < p_gnt);
            out_ready   = ($urandom_range(0, 99) < p_ready);
            out_before  = tb_out;
            if (pend_addr.size() > 0 && pend_rdy[0] <= cyc) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(pend_addr[0]);
                if (redirect || pend_epoch[0] != epoch) tb_dropped++;
                void'(pend_addr.pop_front());
                void'(pend_rdy.pop_front());
                void'(pend_epoch.pop_front());
                tb_out--;
            end else begin
                imem_rvalid = 1'b0;
                imem_rdata  = $urandom;
            end
            #1;
            exp_req = !redirect && (out_before < MAXO) && (sb_q.size() < DEPTH);
            check("imem_req", 64'(imem_req), 64'(exp_req));
            if (imem_req) check("imem_addr", imem_addr, next_addr);
            if (imem_req && imem_gnt) begin
                rdy = cyc + $urandom_range(lat_max, lat_min);
                if (rdy < last_rdy) rdy = last_rdy;
                last_rdy = rdy;
                pend_addr.push_back(imem_addr);
                pend_rdy.push_back(rdy);
                pend_epoch.push_back(epoch);
                tb_out++;
                sb_q.push_back(next_addr);
                next_addr = next_addr + 64'd4;
                if (track_lat && first_acc < 0) first_acc = cyc;
            end
            if (redirect) begin
                sb_q.delete();
                next_addr = {tgt[63:2], 2'b00};
                epoch++;
            end
        end
    endtask

    // Output monitor: independent of stimulus, consumes the scoreboard on each pop.
    always @(negedge clk) begin
        #2;
        if (reset === 1'b1) begin
            if (redir_prev) check("valid_after_redirect", 64'(instr_valid), 64'h0);
            if (instr_valid) begin
                if (track_lat && first_val < 0) first_val = cyc;
                if (out_ready && !redirect) begin
                    if (sb_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL spurious_output @cyc %0d: got pc %0h expected no output", cyc, pc_out);
                    end else begin
                        exp_pc = sb_q.pop_front();
                        check("pc_out", pc_out, exp_pc);
                        check("instr_out", 64'(instr_out), 64'(mem_word(exp_pc)));
                    end
                end
            end else begin
                check("idle_instr_nop", 64'(instr_out), 64'(NOP_INSTR));
                check("idle_pc_zero", pc_out, 64'h0);
                if (out_ready && !redirect) tb_empty++;
            end
            redir_prev = redirect;
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_imem_req"}, 64'(imem_req), 64'h0);
        check({tag, "_imem_addr"}, imem_addr, RESET_PC);
        check({tag, "_instr_valid"}, 64'(instr_valid), 64'h0);
        check({tag, "_instr_out"}, 64'(instr_out), 64'(NOP_INSTR));
        check({tag, "_pc_out"}, pc_out, 64'h0);
    endtask

    task automatic clear_models();
        pend_addr.delete();
        pend_rdy.delete();
        pend_epoch.delete();
        sb_q.delete();
        tb_out     = 0;
        last_rdy   = 0;
        next_addr  = RESET_PC;
        tb_dropped = 0;
        tb_empty   = 0;
        redir_prev = 0;
        epoch++;
    endtask

    initial begin
        reset = 1'b0; redirect = 1'b0; redirect_pc = '0; out_ready = 1'b0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        #1;
        check_reset_outputs("reset");
        repeat (2) @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        // Streaming with single-cycle memory and latency measurement.
        track_lat = 1;
        p_gnt = 100; p_ready = 100; p_redirect = 0; lat_min = 1; lat_max = 1;
        run_cycles(20);
        check("first_output_latency", 64'(first_val - first_acc), 64'd2);
        track_lat = 0;

        // Stall: FIFO fills, requests stop on credits, then drains in order.
        p_ready = 0; lat_max = 2;
        run_cycles(12);
        check("stall_head_valid", 64'(instr_valid), 64'h1);
        p_ready = 100;
        run_cycles(10);

        // Redirect with requests in flight.
        lat_min = 3; lat_max = 3;
        run_cycles(6);
        force_tgt = 1; forced_pc = 64'h102; p_redirect = 100;
        run_cycles(1);
        force_tgt = 0; p_redirect = 0;
        run_cycles(12);

        // Fully randomized traffic.
        p_gnt = 60; p_ready = 70; p_redirect = 5; lat_min = 1; lat_max = 3;
        run_cycles(1500);

        // Asynchronous reset mid-burst.
        p_gnt = 100; p_ready = 100; p_redirect = 0; lat_min = 2; lat_max = 3;
        run_cycles(8);
        @(negedge clk);
        imem_gnt = 1'b0; imem_rvalid = 1'b0; out_ready = 1'b0; redirect = 1'b0;
        #3;
        reset = 1'b0;
        #1;
        check_reset_outputs("midreset");
        clear_models();
        repeat (2) @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("restart_addr", imem_addr, RESET_PC);

        p_gnt = 60; p_ready = 70; p_redirect = 5; lat_min = 1; lat_max = 3;
        run_cycles(300);

        // Drain: no new accepts; every promised word must come out.
        p_gnt = 0; p_ready = 100; p_redirect = 0;
        run_cycles(30);
        check("drain_remaining", 64'(sb_q.size()), 64'h0);
        check("drain_valid", 64'(instr_valid), 64'h0);
`ifdef FETCH_PERF_CNT_EN
        #3;
        check("perf_dropped", 64'(perf_dropped), 64'(tb_dropped));
        check("perf_empty_cycles", 64'(perf_empty_cycles), 64'(tb_empty));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
